l2_cache_arb_stage: RTL and testbench

First stage of the L2 cache pipeline, directly upstream of the tag-lookup stage. Each cycle it selects one request: either a restarted request from the L2 bus interface (a fill returning from memory) or a new core request, chosen round-robin among cores. It registers the winner together with the fill data and fill/flush flags so the tag stage can start SRAM reads on the next edge.

---
 rtl/l2_cache_arb_stage_pkg.sv | 24 ++
 rtl/l2_cache_arb_stage_if.sv | 60 ++++++
 rtl/l2_cache_arb_stage_rr_arbiter.sv | 51 +++++
 rtl/l2_cache_arb_stage.sv | 115 +++++++++++
 tb/tb_l2_cache_arb_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_cache_arb_stage_pkg.sv
// L2 arbitration stage shared types.
// Packet, cache line and core index definitions.
package l2_cache_arb_stage_pkg;

  typedef enum logic [2:0] {
    L2REQ_LOAD,
    L2REQ_STORE,
    L2REQ_FLUSH,
    L2REQ_DINVALIDATE,
    L2REQ_IINVALIDATE
  } l2req_type_t;

  typedef logic [3:0] l2_core_idx_t;

  typedef logic [511:0] cache_line_data_t;

  typedef struct packed {
    l2_core_idx_t core;
    logic [1:0]   id;
    l2req_type_t  packet_type;
    logic [25:0]  address;
  } l2req_packet_t;

endpackage

// File: rtl/l2_cache_arb_stage_if.sv
// L2 arbitration stage bus bundle.
// Core requests, bus-interface restarts and registered stage outputs.
interface l2_cache_arb_stage_if
  import l2_cache_arb_stage_pkg::*;
#(
  parameter int NUM_CORES = 4
) ();

  logic [NUM_CORES-1:0]          l2i_request_valid;
  l2req_packet_t [NUM_CORES-1:0] l2i_request;
  logic [NUM_CORES-1:0]          l2_ready;

  logic             l2bi_request_valid;
  l2req_packet_t    l2bi_request;
  cache_line_data_t l2bi_data_from_memory;
  logic             l2bi_collided_miss;
  logic             l2bi_stall;
  logic             l2a_restart_ack;

  logic             l2a_request_valid;
  l2req_packet_t    l2a_request;
  cache_line_data_t l2a_data_from_memory;
  logic             l2a_l2_fill;
  logic             l2a_restarted_flush;

  modport master (
    output l2i_request_valid,
    output l2i_request,
    input  l2_ready,
    output l2bi_request_valid,
    output l2bi_request,
    output l2bi_data_from_memory,
    output l2bi_collided_miss,
    output l2bi_stall,
    input  l2a_restart_ack,
    input  l2a_request_valid,
    input  l2a_request,
    input  l2a_data_from_memory,
    input  l2a_l2_fill,
    input  l2a_restarted_flush
  );

  modport slave (
    input  l2i_request_valid,
    input  l2i_request,
    output l2_ready,
    input  l2bi_request_valid,
    input  l2bi_request,
    input  l2bi_data_from_memory,
    input  l2bi_collided_miss,
    input  l2bi_stall,
    output l2a_restart_ack,
    output l2a_request_valid,
    output l2a_request,
    output l2a_data_from_memory,
    output l2a_l2_fill,
    output l2a_restarted_flush
  );

endinterface

// File: rtl/l2_cache_arb_stage_rr_arbiter.sv
// Round-robin arbiter with a rotating search pointer.
// Pointer moves past the winner only when update_lru is set.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int PW =
    (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   cand;
  logic          found;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQUESTERS))
        cand = cand - (PW+1)'(NUM_REQUESTERS);
      if (!found && request[cand[PW-1:0]]) begin
        found = 1'b1;
        grant_oh[cand[PW-1:0]] = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  // Advance pointer to the slot after the winner.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (update_lru && found) begin
      if (grant_idx == PW'(NUM_REQUESTERS - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/l2_cache_arb_stage.sv
// L2 pipeline arbitration stage: restart vs round-robin cores.
// Optional restart fairness cap: define L2_ARB_FAIRNESS_EN.
module l2_cache_arb_stage
  import l2_cache_arb_stage_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int MAX_RESTART_RUN = 8
) (
  input logic                 clk,
  input logic                 reset,
  l2_cache_arb_stage_if.slave bus
);

  if (NUM_CORES < 1 || NUM_CORES > 16 ||
      MAX_RESTART_RUN < 1) begin : g_bad_cfg
    $error("l2_cache_arb_stage: bad parameters");
  end

  logic [NUM_CORES-1:0] grant_oh;
  logic                 core_any;
  logic                 core_eligible;
  logic                 starve;
  logic                 restart_ack;
  logic                 core_grant;
  l2req_packet_t        core_pkt;

  logic             a_valid;
  l2req_packet_t    a_req;
  cache_line_data_t a_data;
  logic             a_fill;
  logic             a_flush;

  assign core_any      = |bus.l2i_request_valid;
  assign core_eligible = core_any && !bus.l2bi_stall;

`ifdef L2_ARB_FAIRNESS_EN
  localparam int RUN_W = $clog2(MAX_RESTART_RUN + 1);

  logic [RUN_W-1:0] restart_run;

  assign starve = core_eligible &&
    (restart_run == RUN_W'(MAX_RESTART_RUN));

  // Count restarts that starve a waiting core.
  always_ff @(posedge clk) begin
    if (reset)
      restart_run <= '0;
    else if (core_grant)
      restart_run <= '0;
    else if (restart_ack && core_eligible &&
             restart_run != RUN_W'(MAX_RESTART_RUN))
      restart_run <= restart_run + RUN_W'(1);
  end
`else
  assign starve = 1'b0;
`endif

  assign restart_ack = !reset && bus.l2bi_request_valid && !starve;
  assign core_grant  = !reset && !restart_ack && core_eligible;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_CORES)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .request   (bus.l2i_request_valid),
    .update_lru(core_grant),
    .grant_oh  (grant_oh)
  );

  // Select the granted core's packet.
  always_comb begin
    core_pkt = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (grant_oh[i])
        core_pkt = bus.l2i_request[i];
  end

  assign bus.l2_ready = core_grant ? grant_oh : '0;
  assign bus.l2a_restart_ack = restart_ack;

  // Register the winner for the tag stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_req   <= '0;
      a_data  <= '0;
      a_fill  <= 1'b0;
      a_flush <= 1'b0;
    end else if (restart_ack) begin
      a_valid <= 1'b1;
      a_req   <= bus.l2bi_request;
      a_data  <= bus.l2bi_data_from_memory;
      a_fill  <= !bus.l2bi_collided_miss;
      a_flush <= bus.l2bi_request.packet_type == L2REQ_FLUSH;
    end else if (core_grant) begin
      a_valid <= 1'b1;
      a_req   <= core_pkt;
      a_data  <= bus.l2bi_data_from_memory;
      a_fill  <= 1'b0;
      a_flush <= 1'b0;
    end else begin
      a_valid <= 1'b0;
      a_fill  <= 1'b0;
      a_flush <= 1'b0;
    end
  end

  assign bus.l2a_request_valid    = a_valid;
  assign bus.l2a_request          = a_req;
  assign bus.l2a_data_from_memory = a_data;
  assign bus.l2a_l2_fill          = a_fill;
  assign bus.l2a_restarted_flush  = a_flush;

endmodule

// File: tb/tb_l2_cache_arb_stage.sv
// Directed bench for l2_cache_arb_stage (4 cores).
// Build with +define+L2_ARB_FAIRNESS_EN to cover the fairness cap.
module tb_l2_cache_arb_stage;
  import l2_cache_arb_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_cache_arb_stage_if #(.NUM_CORES(4)) bif ();

  l2_cache_arb_stage #(
    .NUM_CORES(4),
    .MAX_RESTART_RUN(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  cache_line_data_t line_a;
  cache_line_data_t line_b;
  l2req_packet_t    pkts [4];

  function automatic l2req_packet_t mk(int c, l2req_type_t t,
                                       logic [25:0] a);
    l2req_packet_t p;
    p.core        = 4'(c);
    p.id          = 2'(c);
    p.packet_type = t;
    p.address     = a;
    return p;
  endfunction

  task automatic idle_inputs();
    bif.l2i_request_valid     = '0;
    bif.l2bi_request_valid    = 1'b0;
    bif.l2bi_collided_miss    = 1'b0;
    bif.l2bi_stall            = 1'b0;
    bif.l2bi_request          = '0;
    bif.l2bi_data_from_memory = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.l2i_request_valid  = 4'b1111;
    bif.l2bi_request_valid = 1'b1;
    bif.l2bi_request       = mk(1, L2REQ_LOAD, 26'h1);
    bif.l2bi_data_from_memory = line_a;
    #1;
    checks++;
    if (bif.l2_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0000", bif.l2_ready);
    end
    checks++;
    if (bif.l2a_restart_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", bif.l2a_restart_ack);
    end
    step();
    checks++;
    if (bif.l2a_request_valid !== 1'b0 || bif.l2a_l2_fill !== 1'b0 ||
        bif.l2a_restarted_flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got v%b f%b fl%b want 000",
               bif.l2a_request_valid, bif.l2a_l2_fill,
               bif.l2a_restarted_flush);
    end
    checks++;
    if (bif.l2a_request !== '0 || bif.l2a_data_from_memory !== '0) begin
      errors++;
      $display("FAIL reset_regs: got req %h want 0", bif.l2a_request);
    end
    idle_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_rr_two();
    logic [3:0] exp_rdy [3];
    int         exp_core [3];
    exp_rdy[0] = 4'b0001; exp_core[0] = 0;
    exp_rdy[1] = 4'b0100; exp_core[1] = 2;
    exp_rdy[2] = 4'b0001; exp_core[2] = 0;
    do_reset();
    bif.l2i_request_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bif.l2_ready !== exp_rdy[k]) begin
        errors++;
        $display("FAIL rr_two_ready[%0d]: got %b want %b",
                 k, bif.l2_ready, exp_rdy[k]);
      end
      step();
      checks++;
      if (bif.l2a_request_valid !== 1'b1 || bif.l2a_l2_fill !== 1'b0 ||
          bif.l2a_request !== pkts[exp_core[k]]) begin
        errors++;
        $display("FAIL rr_two_out[%0d]: got v%b f%b req %h want v1 f0 %h",
                 k, bif.l2a_request_valid, bif.l2a_l2_fill,
                 bif.l2a_request, pkts[exp_core[k]]);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (bif.l2a_request_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_two_idle: got %b want 0", bif.l2a_request_valid);
    end
  endtask

  task automatic test_rr_all();
    logic [3:0] exp;
    do_reset();
    bif.l2i_request_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      #1;
      checks++;
      if (bif.l2_ready !== exp) begin
        errors++;
        $display("FAIL rr_all_ready[%0d]: got %b want %b",
                 k, bif.l2_ready, exp);
      end
      step();
      checks++;
      if (bif.l2a_request !== pkts[k % 4]) begin
        errors++;
        $display("FAIL rr_all_req[%0d]: got %h want %h",
                 k, bif.l2a_request, pkts[k % 4]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_restart_load();
    l2req_packet_t rp;
    rp = mk(2, L2REQ_LOAD, 26'h2abcd);
    idle_inputs();
    bif.l2i_request_valid     = 4'b0010;
    bif.l2bi_request_valid    = 1'b1;
    bif.l2bi_request          = rp;
    bif.l2bi_data_from_memory = line_b;
    #1;
    checks++;
    if (bif.l2a_restart_ack !== 1'b1 || bif.l2_ready !== 4'b0000) begin
      errors++;
      $display("FAIL restart_load_grant: got ack %b rdy %b want 1 0000",
               bif.l2a_restart_ack, bif.l2_ready);
    end
    step();
    checks++;
    if (bif.l2a_request_valid !== 1'b1 || bif.l2a_l2_fill !== 1'b1 ||
        bif.l2a_restarted_flush !== 1'b0 || bif.l2a_request !== rp) begin
      errors++;
      $display("FAIL restart_load_out: got v%b f%b fl%b req %h want 1 1 0 %h",
               bif.l2a_request_valid, bif.l2a_l2_fill,
               bif.l2a_restarted_flush, bif.l2a_request, rp);
    end
    checks++;
    if (bif.l2a_data_from_memory !== line_b) begin
      errors++;
      $display("FAIL restart_load_data: got %h want %h",
               bif.l2a_data_from_memory[63:0], line_b[63:0]);
    end
    idle_inputs();
  endtask

  task automatic test_restart_flush();
    idle_inputs();
    bif.l2bi_request_valid = 1'b1;
    bif.l2bi_collided_miss = 1'b1;
    bif.l2bi_request       = mk(3, L2REQ_FLUSH, 26'h3f00);
    #1;
    checks++;
    if (bif.l2a_restart_ack !== 1'b1) begin
      errors++;
      $display("FAIL restart_flush_ack: got %b want 1",
               bif.l2a_restart_ack);
    end
    step();
    checks++;
    if (bif.l2a_request_valid !== 1'b1 || bif.l2a_l2_fill !== 1'b0 ||
        bif.l2a_restarted_flush !== 1'b1) begin
      errors++;
      $display("FAIL restart_flush_out: got v%b f%b fl%b want 1 0 1",
               bif.l2a_request_valid, bif.l2a_l2_fill,
               bif.l2a_restarted_flush);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    bif.l2i_request_valid = 4'b0001;
    step();
    bif.l2i_request_valid = 4'b1111;
    bif.l2bi_stall        = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bif.l2_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b want 0000",
                 k, bif.l2_ready);
      end
      step();
      checks++;
      if (bif.l2a_request_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_valid[%0d]: got %b want 0",
                 k, bif.l2a_request_valid);
      end
    end
    bif.l2bi_stall = 1'b0;
    #1;
    checks++;
    if (bif.l2_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_ptr_held: got %b want 0010", bif.l2_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bif.l2i_request_valid = 4'b1000;
    step();
    checks++;
    if (bif.l2a_request_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got %b want 1", bif.l2a_request_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bif.l2_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_ready: got %b want 0000", bif.l2_ready);
    end
    step();
    checks++;
    if (bif.l2a_request_valid !== 1'b0 || bif.l2a_request !== '0) begin
      errors++;
      $display("FAIL midreset_out: got v%b req %h want 0 0",
               bif.l2a_request_valid, bif.l2a_request);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

`ifdef L2_ARB_FAIRNESS_EN
  task automatic test_fairness();
    logic       exp_ack;
    logic [3:0] exp_rdy;
    do_reset();
    bif.l2i_request_valid  = 4'b1000;
    bif.l2bi_request_valid = 1'b1;
    bif.l2bi_request       = mk(1, L2REQ_LOAD, 26'h55);
    for (int k = 0; k < 11; k++) begin
      exp_ack = (k != 8);
      exp_rdy = (k == 8) ? 4'b1000 : 4'b0000;
      #1;
      checks++;
      if (bif.l2a_restart_ack !== exp_ack || bif.l2_ready !== exp_rdy) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got ack %b rdy %b want %b %b",
                 k, bif.l2a_restart_ack, bif.l2_ready, exp_ack, exp_rdy);
      end
      step();
      if (k == 8) begin
        checks++;
        if (bif.l2a_request !== pkts[3] || bif.l2a_l2_fill !== 1'b0) begin
          errors++;
          $display("FAIL fair_core_out: got %h f%b want %h f0",
                   bif.l2a_request, bif.l2a_l2_fill, pkts[3]);
        end
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bif.l2a_restart_ack !== 1'b0) begin
      errors++;
      $display("FAIL fair_reset_ack: got %b want 0", bif.l2a_restart_ack);
    end
    step();
    checks++;
    if (bif.l2a_request_valid !== 1'b0) begin
      errors++;
      $display("FAIL fair_reset_valid: got %b want 0",
               bif.l2a_request_valid);
    end
    reset = 1'b0;
    idle_inputs();
  endtask
`else
  task automatic test_restart_wins();
    do_reset();
    bif.l2i_request_valid  = 4'b1000;
    bif.l2bi_request_valid = 1'b1;
    bif.l2bi_request       = mk(1, L2REQ_LOAD, 26'h55);
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (bif.l2a_restart_ack !== 1'b1 || bif.l2_ready !== 4'b0000) begin
        errors++;
        $display("FAIL restart_wins[%0d]: got ack %b rdy %b want 1 0000",
                 k, bif.l2a_restart_ack, bif.l2_ready);
      end
      step();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    line_a = {8{64'h0123_4567_89ab_cdef}};
    line_b = {16{32'hc0de_f00d}};
    for (int i = 0; i < 4; i++)
      pkts[i] = mk(i, L2REQ_STORE, 26'(32'h100 * (i + 1)));
    for (int i = 0; i < 4; i++)
      bif.l2i_request[i] = pkts[i];
    idle_inputs();
    step();
    test_reset();
    test_rr_two();
    test_rr_all();
    test_restart_load();
    test_restart_flush();
    test_stall();
    test_reset_midstream();
`ifdef L2_ARB_FAIRNESS_EN
    test_fairness();
`else
    test_restart_wins();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
